// File: rtl/cpu_alu_unit_pkg.sv
// Shared constants for the conditionally executing ALU: widths, opcodes,
// condition codes and flag bit positions inside {N,Z,C,V}.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int IMM_W   = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_ORR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_EOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LSR  = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h8;
  localparam logic [3:0] OP_ROR  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_MVN  = 4'hB;
  localparam logic [3:0] OP_LDR  = 4'hC;
  localparam logic [3:0] OP_STR  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/cpu_alu_unit_if.sv
// Instruction-field and result bundle between the CPU datapath (master)
// and the ALU (slave).
interface cpu_alu_unit_if;
  import alu_pkg::*;

  logic [DATA_W-1:0]  Reg1;
  logic [DATA_W-1:0]  Reg2;
  logic [SHAMT_W-1:0] IV_ShftRor;
  logic [IMM_W-1:0]   IV_Mov;
  logic [3:0]         OpCode;
  logic [3:0]         Cond;
  logic               S;
  logic [3:0]         Flag;
  logic [DATA_W-1:0]  Result;
  logic [3:0]         New_Flag;
  logic               memory_enable;

  modport master (
    output Reg1, Reg2, IV_ShftRor, IV_Mov, OpCode, Cond, S, Flag,
    input  Result, New_Flag, memory_enable
  );

  modport slave (
    input  Reg1, Reg2, IV_ShftRor, IV_Mov, OpCode, Cond, S, Flag,
    output Result, New_Flag, memory_enable
  );

endinterface

// File: rtl/cpu_alu_unit_cond_eval.sv
// ARM-style condition check: decides from the current {N,Z,C,V} whether
// the instruction executes.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flag,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flag[FLG_N];
  assign w_z = i_flag[FLG_Z];
  assign w_c = i_flag[FLG_C];
  assign w_v = i_flag[FLG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_alu_unit.sv
// Conditionally executing 32-bit ALU with registered Result/New_Flag/memory_enable.
// Build option ALU_MUL_EN: enables the opcode-2 multiplier (otherwise opcode 2 is reserved).
module cpu_alu_unit
  import alu_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  cpu_alu_unit_if.slave alu_bus
);

  logic [DATA_W-1:0]  w_a, w_b, w_sub, w_ror, w_value, w_result, r_result;
  logic [SHAMT_W-1:0] w_sh;
  logic [DATA_W:0]    w_add, w_lsl, w_lsr;
  logic [3:0]         w_flag, r_flag;
  logic               w_pass, w_mem, r_mem, w_c, w_v, w_setFlags;
  logic               w_addV, w_subV, w_subC;

  assign w_a  = alu_bus.Reg1;
  assign w_b  = alu_bus.Reg2;
  assign w_sh = alu_bus.IV_ShftRor;

  alu_cond_eval u_cond (
    .i_cond (alu_bus.Cond),
    .i_flag (alu_bus.Flag),
    .o_pass (w_pass)
  );

  assign w_add  = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub  = w_a - w_b;
  assign w_subC = (w_a >= w_b);
  assign w_addV = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_add[DATA_W-1] != w_a[DATA_W-1]);
  assign w_subV = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_sub[DATA_W-1] != w_a[DATA_W-1]);

  // Extra guard bit on each side catches the last bit shifted out as the carry.
  assign w_lsl = {1'b0, w_a} << w_sh;
  assign w_lsr = {w_a, 1'b0} >> w_sh;
  assign w_ror = (w_a >> w_sh) | (w_a << (6'd32 - {1'b0, w_sh}));

`ifdef ALU_MUL_EN
  logic [DATA_W-1:0] w_mul;
  assign w_mul = w_a * w_b;
`endif

  always_comb begin
    w_result   = r_result;
    w_flag     = alu_bus.Flag;
    w_mem      = 1'b0;
    w_value    = '0;
    w_c        = alu_bus.Flag[FLG_C];
    w_v        = alu_bus.Flag[FLG_V];
    w_setFlags = 1'b0;
    if (w_pass) begin
      w_setFlags = alu_bus.S;
      case (alu_bus.OpCode)
        OP_ADD: begin w_value = w_add[DATA_W-1:0]; w_c = w_add[DATA_W]; w_v = w_addV; end
        OP_SUB: begin w_value = w_sub; w_c = w_subC; w_v = w_subV; end
        OP_MUL: begin
`ifdef ALU_MUL_EN
          w_value = w_mul;
`else
          w_setFlags = 1'b0;
`endif
        end
        OP_ORR: w_value = w_a | w_b;
        OP_AND: w_value = w_a & w_b;
        OP_EOR: w_value = w_a ^ w_b;
        OP_MOV: w_value = {{(DATA_W-IMM_W){1'b0}}, alu_bus.IV_Mov};
        OP_LSR: begin w_value = w_lsr[DATA_W:1]; if (w_sh != '0) w_c = w_lsr[0]; end
        OP_LSL: begin w_value = w_lsl[DATA_W-1:0]; if (w_sh != '0) w_c = w_lsl[DATA_W]; end
        OP_ROR: begin w_value = w_ror; if (w_sh != '0) w_c = w_ror[DATA_W-1]; end
        OP_CMP: begin w_value = w_sub; w_c = w_subC; w_v = w_subV; w_setFlags = 1'b1; end
        OP_MVN: w_value = ~w_b;
        OP_LDR, OP_STR: begin w_value = w_add[DATA_W-1:0]; w_mem = 1'b1; w_setFlags = 1'b0; end
        default: w_setFlags = 1'b0;
      endcase
      // CMP and NOP leave the result register untouched.
      if (alu_bus.OpCode != OP_CMP && alu_bus.OpCode != OP_NOP) w_result = w_value;
      if (w_setFlags) w_flag = {w_value[DATA_W-1], (w_value == '0), w_c, w_v};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_result <= '0;
      r_flag   <= '0;
      r_mem    <= 1'b0;
    end else begin
      r_result <= w_result;
      r_flag   <= w_flag;
      r_mem    <= w_mem;
    end
  end

  assign alu_bus.Result        = r_result;
  assign alu_bus.New_Flag      = r_flag;
  assign alu_bus.memory_enable = r_mem;

endmodule

// File: tb/tb_cpu_alu_unit.sv
// Directed plus randomized bench for cpu_alu_unit with an arithmetic reference model.
module tb_cpu_alu_unit;
  import alu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  int          total = 0;
  int          bad = 0;
  logic [31:0] expResult;
  logic [3:0]  expFlag;
  logic        expMem;

  cpu_alu_unit_if aluBus ();

  cpu_alu_unit dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .alu_bus (aluBus)
  );

  always #5 Clk = ~Clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".Result"}, aluBus.Result, expResult);
    checkValue({tag, ".New_Flag"}, 32'(aluBus.New_Flag), 32'(expFlag));
    checkValue({tag, ".memory_enable"}, 32'(aluBus.memory_enable), 32'(expMem));
  endtask

  // Reference model: plain 64-bit arithmetic and bit-at-a-time shifting.
  task automatic modelStep(input logic [3:0] opc, input logic [3:0] cnd, input logic s,
                           input logic [3:0] flg, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [15:0] mv);
    bit n, z, c, v, pass, cOut, vOut, writeRes, setFlags;
    logic [31:0] r;
    longint u, ss;
    n = flg[3]; z = flg[2]; c = flg[1]; v = flg[0];
    case (cnd)
      4'h0: pass = z;          4'h1: pass = !z;
      4'h2: pass = c;          4'h3: pass = !c;
      4'h4: pass = n;          4'h5: pass = !n;
      4'h6: pass = v;          4'h7: pass = !v;
      4'h8: pass = c && !z;    4'h9: pass = !c || z;
      4'hA: pass = (n == v);   4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v);
      4'hD: pass = z || (n != v);
      4'hE: pass = 1;
      default: pass = 0;
    endcase
    expMem = 0;
    expFlag = flg;
    if (!pass) return;
    cOut = c; vOut = v; writeRes = 1; setFlags = s; r = '0;
    case (opc)
      4'h0: begin
        u = longint'(a) + longint'(b);
        r = u[31:0];
        cOut = (u >> 32) != 0;
        ss = longint'($signed(a)) + longint'($signed(b));
        vOut = ss != longint'($signed(r));
      end
      4'h1, 4'hA: begin
        r = a - b;
        cOut = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        vOut = ss != longint'($signed(r));
        if (opc == 4'hA) begin writeRes = 0; setFlags = 1; end
      end
      4'h2: begin
`ifdef ALU_MUL_EN
        r = a * b;
`else
        r = '0; setFlags = 0;
`endif
      end
      4'h3: r = a | b;
      4'h4: r = a & b;
      4'h5: r = a ^ b;
      4'h6: r = {16'h0000, mv};
      4'h7, 4'h8, 4'h9: begin
        r = a;
        for (int i = 0; i < int'(sh); i++) begin
          if (opc == 4'h7) begin cOut = r[0]; r = r >> 1; end
          else if (opc == 4'h8) begin cOut = r[31]; r = r << 1; end
          else begin cOut = r[0]; r = {r[0], r[31:1]}; end
        end
      end
      4'hB: r = ~b;
      4'hC, 4'hD: begin r = a + b; expMem = 1; setFlags = 0; end
      4'hE: begin writeRes = 0; setFlags = 0; end
      default: begin r = '0; setFlags = 0; end
    endcase
    if (writeRes) expResult = r;
    if (setFlags) expFlag = {r[31], r == 0, cOut, vOut};
  endtask

  task automatic applyStimulus(input logic [3:0] opc, input logic [3:0] cnd, input logic s,
                               input logic [3:0] flg, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic [15:0] mv);
    @(negedge Clk);
    aluBus.OpCode = opc; aluBus.Cond = cnd; aluBus.S = s; aluBus.Flag = flg;
    aluBus.Reg1 = a; aluBus.Reg2 = b; aluBus.IV_ShftRor = sh; aluBus.IV_Mov = mv;
    @(posedge Clk);
    #1;
    if (Reset) modelStep(opc, cnd, s, flg, a, b, sh, mv);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] edges [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h10};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [3:0] rOp, rCond, rFlag;
    Reset = 1'b0;
    aluBus.OpCode = OP_NOP; aluBus.Cond = COND_AL; aluBus.S = 1'b0; aluBus.Flag = 4'h0;
    aluBus.Reg1 = '0; aluBus.Reg2 = '0; aluBus.IV_ShftRor = '0; aluBus.IV_Mov = '0;
    expResult = '0; expFlag = '0; expMem = 1'b0;
    #2;
    checkOutput("reset");
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    applyStimulus(OP_ADD, COND_AL, 1'b1, 4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0, 16'h0);
    checkOutput("addOvf");
    checkValue("addOvf.litResult", aluBus.Result, 32'h80000000);
    checkValue("addOvf.litFlag", 32'(aluBus.New_Flag), 32'h9);

    applyStimulus(OP_SUB, COND_AL, 1'b1, 4'b1001, 32'd5, 32'd5, 5'd0, 16'h0);
    checkOutput("subZero");
    checkValue("subZero.litResult", aluBus.Result, 32'h0);
    checkValue("subZero.litFlag", 32'(aluBus.New_Flag), 32'h6);

    applyStimulus(OP_MOV, COND_EQ, 1'b0, 4'b0110, 32'h0, 32'h0, 5'd0, 16'h1234);
    checkOutput("movEq");
    checkValue("movEq.litResult", aluBus.Result, 32'h00001234);

    applyStimulus(OP_MOV, COND_NE, 1'b0, 4'b0100, 32'h0, 32'h0, 5'd0, 16'h5678);
    checkOutput("movNeSkip");
    checkValue("movNeSkip.litResult", aluBus.Result, 32'h00001234);
    checkValue("movNeSkip.litFlag", 32'(aluBus.New_Flag), 32'h4);

    applyStimulus(OP_ROR, COND_AL, 1'b1, 4'b0000, 32'h1, 32'h0, 5'd1, 16'h0);
    checkOutput("ror1");
    checkValue("ror1.litResult", aluBus.Result, 32'h80000000);
    checkValue("ror1.litFlag", 32'(aluBus.New_Flag), 32'hA);

    applyStimulus(OP_LDR, COND_AL, 1'b1, 4'b0000, 32'h10, 32'h4, 5'd0, 16'h0);
    checkOutput("ldr");
    checkValue("ldr.litResult", aluBus.Result, 32'h14);
    checkValue("ldr.litMem", 32'(aluBus.memory_enable), 32'h1);

    applyStimulus(OP_NOP, COND_AL, 1'b1, 4'b0000, 32'h10, 32'h4, 5'd0, 16'h0);
    checkOutput("nop");
    checkValue("nop.litMem", 32'(aluBus.memory_enable), 32'h0);

    applyStimulus(OP_CMP, COND_AL, 1'b0, 4'b0000, 32'd3, 32'd7, 5'd0, 16'h0);
    checkOutput("cmpBorrow");
    checkValue("cmpBorrow.litResult", aluBus.Result, 32'h14);
    checkValue("cmpBorrow.litFlag", 32'(aluBus.New_Flag), 32'h8);

    applyStimulus(OP_LSL, COND_AL, 1'b1, 4'b0010, 32'h80000001, 32'h0, 5'd0, 16'h0);
    checkOutput("lslZero");
    applyStimulus(OP_LSR, COND_AL, 1'b1, 4'b0000, 32'h80000001, 32'h0, 5'd31, 16'h0);
    checkOutput("lsr31");
    applyStimulus(OP_STR, COND_NV, 1'b1, 4'b0000, 32'h10, 32'h4, 5'd0, 16'h0);
    checkOutput("strNever");
    applyStimulus(OP_RSVD, COND_AL, 1'b1, 4'b1111, 32'h5, 32'h6, 5'd0, 16'h0);
    checkOutput("reserved");

    for (int i = 0; i < 400; i++) begin
      rOp   = 4'($urandom_range(0, 15));
      rCond = ($urandom_range(0, 1) == 0) ? COND_AL : 4'($urandom_range(0, 15));
      rFlag = 4'($urandom_range(0, 15));
      applyStimulus(rOp, rCond, 1'($urandom_range(0, 1)), rFlag, pickOperand(), pickOperand(),
                    5'($urandom_range(0, 31)), 16'($urandom));
      checkOutput($sformatf("rand%0d", i));
    end

    applyStimulus(OP_ADD, COND_AL, 1'b1, 4'b0000, 32'h1234, 32'h1, 5'd0, 16'h0);
    checkOutput("preReset");
    #3;
    Reset = 1'b0;
    expResult = '0; expFlag = '0; expMem = 1'b0;
    #1;
    checkOutput("asyncReset");
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("resetHold");
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(OP_LDR, COND_AL, 1'b0, 4'b0000, 32'h20, 32'h8, 5'd0, 16'h0);
    checkOutput("afterReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
